// File: rtl/slave_internal_response_rd_arbiter.sv
// slave_internal_response_rd_arbiter
// Merges NUM_SRC internal read-response sources (0 = error path, 1 = posted
// path, ...) into one registered R channel. A two-state FSM tracks whether
// the output register holds a response. A new winner can be loaded on the
// same edge that the held response drains, so there is no bubble.
// Build option SLV_RD_ARB_FIXED_PRIO_EN: drop the round-robin pointer and
// always grant the highest-indexed valid source.
module slave_internal_response_rd_arbiter #(
    parameter int          NUM_SRC      = 2,
    parameter int          ID_WIDTH     = 8,
    parameter int          SRC_W        = $clog2(NUM_SRC),
    // RRESP value shown while the output register is empty after reset
    parameter logic [1:0]  RESP_INVALID = 2'b11
) (
    input  logic                               ACLK,
    input  logic                               ARESETn,
    input  logic [NUM_SRC-1:0]                 in_rvalid,
    output logic [NUM_SRC-1:0]                 in_rready,
    input  logic [NUM_SRC-1:0][ID_WIDTH-1:0]   in_rid,
    input  logic [NUM_SRC-1:0][1:0]            in_rresp,
    output logic                               out_rvalid,
    input  logic                               out_rready,
    output logic [ID_WIDTH-1:0]                out_rid,
    output logic [1:0]                         out_rresp,
    output logic [SRC_W-1:0]                   out_src
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [SRC_W-1:0] win;
    logic             grant;
    logic             any_req;

    assign any_req = |in_rvalid;

`ifdef SLV_RD_ARB_FIXED_PRIO_EN
    // Fixed priority: the highest-indexed valid source overrides lower ones
    always_comb begin
        win = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (in_rvalid[i]) win = SRC_W'(i);
        end
    end
`else
    logic [SRC_W-1:0] last_grant;
    logic [SRC_W:0]   idx;

    // Round-robin: scan offsets NUM_SRC..1 from last_grant so the nearest
    // valid source after last_grant is the final assignment and wins
    always_comb begin
        win = last_grant;
        idx = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = {1'b0, last_grant} + (SRC_W+1)'(k);
            if (idx >= (SRC_W+1)'(NUM_SRC)) idx = idx - (SRC_W+1)'(NUM_SRC);
            if (in_rvalid[idx[SRC_W-1:0]]) win = idx[SRC_W-1:0];
        end
    end

    // Pointer starts at NUM_SRC-1 so the first search begins at source 0
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)   last_grant <= SRC_W'(NUM_SRC - 1);
        else if (grant) last_grant <= win;
    end
`endif

    // FSM state register
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Grant, pop strobe and next state; reset gates the pop strobe off
    always_comb begin
        state_nxt = state;
        grant     = ARESETn && any_req && ((state == IDLE) || out_rready);
        in_rready = '0;
        if (grant) in_rready = NUM_SRC'(1) << win;
        case (state)
            IDLE: if (grant) state_nxt = HOLD;
            HOLD: if (out_rready && !any_req) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output register: load the winner on grant, otherwise hold
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            out_rid   <= '0;
            out_rresp <= RESP_INVALID;
            out_src   <= '0;
        end else if (grant) begin
            out_rid   <= in_rid[win];
            out_rresp <= in_rresp[win];
            out_src   <= win;
        end
    end

    assign out_rvalid = (state == HOLD);

endmodule

// File: tb/tb_slave_internal_response_rd_arbiter.sv
// Bench for slave_internal_response_rd_arbiter: a 2-source and a 4-source
// instance run side by side against a transaction-level reference model.
module tb_slave_internal_response_rd_arbiter;

    localparam logic [1:0] INV = 2'b11;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [1:0]       v2, rdy2, ors2;
    logic [1:0][7:0]  id2;
    logic [1:0][1:0]  rs2;
    logic             ov2, or2;
    logic [7:0]       oid2;
    logic [0:0]       osrc2;

    logic [3:0]       v4, rdy4;
    logic [3:0][7:0]  id4;
    logic [3:0][1:0]  rs4;
    logic             ov4, or4;
    logic [7:0]       oid4;
    logic [1:0]       ors4, osrc4;

    slave_internal_response_rd_arbiter #(.NUM_SRC(2), .ID_WIDTH(8)) u2 (
        .ACLK(clk), .ARESETn(rst_n), .in_rvalid(v2), .in_rready(rdy2),
        .in_rid(id2), .in_rresp(rs2), .out_rvalid(ov2), .out_rready(or2),
        .out_rid(oid2), .out_rresp(ors2), .out_src(osrc2));

    slave_internal_response_rd_arbiter #(.NUM_SRC(4), .ID_WIDTH(8)) u4 (
        .ACLK(clk), .ARESETn(rst_n), .in_rvalid(v4), .in_rready(rdy4),
        .in_rid(id4), .in_rresp(rs4), .out_rvalid(ov4), .out_rready(or4),
        .out_rid(oid4), .out_rresp(ors4), .out_src(osrc4));

    int total = 0;
    int bad   = 0;

    // Reference model, index 0 = 2-source instance, 1 = 4-source instance
    int nsrc[2] = '{2, 4};
    int m_full[2], m_rid[2], m_rresp[2], m_src[2], m_last[2], m_g[2];

    // Winner for a request mask; -1 when nobody asks
    function automatic int pick(int last, int v, int n);
`ifdef SLV_RD_ARB_FIXED_PRIO_EN
        for (int i = n - 1; i >= 0; i--) if (v[i]) return i;
`else
        for (int k = 1; k <= n; k++) if (v[(last + k) % n]) return (last + k) % n;
`endif
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_full[d] = 0; m_rid[d] = 0; m_rresp[d] = int'(INV);
            m_src[d] = 0;  m_last[d] = nsrc[d] - 1;
        end
    endtask

    task automatic check_outs(string tag);
        chk({tag, ".ov2"},   ov2,   m_full[0]);
        chk({tag, ".oid2"},  oid2,  m_rid[0]);
        chk({tag, ".ors2"},  ors2,  m_rresp[0]);
        chk({tag, ".osrc2"}, osrc2, m_src[0]);
        chk({tag, ".ov4"},   ov4,   m_full[1]);
        chk({tag, ".oid4"},  oid4,  m_rid[1]);
        chk({tag, ".ors4"},  ors4,  m_rresp[1]);
        chk({tag, ".osrc4"}, osrc4, m_src[1]);
    endtask

    // One clock: entered at a negedge with inputs already driven
    task automatic cycle(string tag);
        #1;
        m_g[0] = (m_full[0] == 0 || or2) ? pick(m_last[0], int'(v2), 2) : -1;
        m_g[1] = (m_full[1] == 0 || or4) ? pick(m_last[1], int'(v4), 4) : -1;
        chk({tag, ".rdy2"}, rdy2, (m_g[0] >= 0) ? (1 << m_g[0]) : 0);
        chk({tag, ".rdy4"}, rdy4, (m_g[1] >= 0) ? (1 << m_g[1]) : 0);
        @(posedge clk);
        if (m_g[0] >= 0) begin
            m_full[0] = 1; m_rid[0] = int'(id2[m_g[0]]);
            m_rresp[0] = int'(rs2[m_g[0]]); m_src[0] = m_g[0]; m_last[0] = m_g[0];
        end else if (m_full[0] != 0 && or2) m_full[0] = 0;
        if (m_g[1] >= 0) begin
            m_full[1] = 1; m_rid[1] = int'(id4[m_g[1]]);
            m_rresp[1] = int'(rs4[m_g[1]]); m_src[1] = m_g[1]; m_last[1] = m_g[1];
        end else if (m_full[1] != 0 && or4) m_full[1] = 0;
        #1;
        check_outs(tag);
        @(negedge clk);
    endtask

    initial begin
        // Reset with requests already pending: no pops while in reset
        rst_n = 1'b0;
        v2 = 2'b11; id2 = '{8'h22, 8'h11}; rs2 = '{2'b00, 2'b10}; or2 = 1'b1;
        v4 = 4'hF;  id4 = '{8'h44, 8'h33, 8'h22, 8'h11}; rs4 = '0; or4 = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.rdy2", rdy2, 0);
        chk("rst.rdy4", rdy4, 0);
        check_outs("rst");
        v2 = 2'b00; v4 = 4'h0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester on the posted path
        v2 = 2'b10; id2[1] = 8'h05; rs2[1] = 2'b00; or2 = 1'b1;
        cycle("single");
        chk("single.oid", oid2, 8'h05);
        chk("single.src", osrc2, 1);

        // Both sources continuously valid, downstream always ready
        v2 = 2'b11; id2 = '{8'hB1, 8'hA0}; rs2 = '{2'b01, 2'b10};
        v4 = 4'hF;
        for (int i = 0; i < 4; i++) begin
            cycle("b2b");
            chk("b2b.valid", ov2, 1);
        end

        // Stall with RID 3A held for 5 cycles
        id2 = '{8'h3A, 8'h3A};
        cycle("load3a");
        or2 = 1'b0; or4 = 1'b0; id2 = '{8'h77, 8'h66};
        for (int i = 0; i < 5; i++) begin
            cycle("stall");
            chk("stall.oid", oid2, 8'h3A);
            chk("stall.rdy", rdy2, 0);
        end
        or2 = 1'b1;
        cycle("unstall");
        v2 = 2'b00;
        cycle("drain");
        chk("drain.valid", ov2, 0);

        // Asynchronous reset while holding, then all four valid
        or4 = 1'b0; v4 = 4'hF;
        cycle("pre_rst");
        rst_n = 1'b0;
        #1;
        chk("arst.ov4", ov4, 0);
        chk("arst.ors4", ors4, INV);
        model_reset();
        check_outs("arst");
        @(negedge clk);
        rst_n = 1'b1; or4 = 1'b1; v4 = 4'hF;
        cycle("post_rst");
`ifdef SLV_RD_ARB_FIXED_PRIO_EN
        chk("post_rst.first", osrc4, 3);
`else
        chk("post_rst.first", osrc4, 0);
`endif

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            v2 = 2'($urandom_range(0, 3));
            v4 = 4'($urandom_range(0, 15));
            id2 = 16'($urandom);
            id4 = $urandom;
            rs2 = 4'($urandom);
            rs4 = 8'($urandom);
            or2 = ($urandom_range(0, 3) != 0);
            or4 = ($urandom_range(0, 3) != 0);
            cycle("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
